// File: rtl/register_bank_arbiter_pkg.sv
// Shared definitions for the two-requester register bank arbiter.
//   state_e  : transaction FSM encoding (IDLE / ACCESS / RESPOND)
//   OWNER_A / OWNER_B : requester identifiers used for owner and last_served
`ifndef REGISTER_BANK_ARBITER_PKG_SV
`define REGISTER_BANK_ARBITER_PKG_SV

package register_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

`endif

// File: rtl/round_robin_arbiter_2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req_a, req_b  : pending requests
//   last_served   : requester that owned the previous transaction
//   winner        : requester to serve next (valid only when any_req)
//   any_req       : at least one request pending
module round_robin_arbiter_2
  import register_bank_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_served,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req_a | req_b;
    if (req_a && req_b) begin
      // Tie: whoever was not served last goes next, giving strict alternation.
      winner = ~last_served;
    end else if (req_b) begin
      winner = OWNER_B;
    end else begin
      winner = OWNER_A;
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Register bank shared between requesters A and B. Each transaction is one
// read or write and takes three cycles: IDLE (arbitrate + latch command),
// ACCESS (grant, storage update at closing edge), RESPOND (done pulse).
// Ports:
//   clock, reset_n                       : clock, synchronous active-low reset
//   req_x, write_x, addr_x, wdata_x      : requester x command (x = a, b)
//   grant_a, grant_b                     : owner holds the bank (ACCESS cycle)
//   done_a, done_b                       : one-cycle completion pulse
//   rdata                                : read data, or the word just written
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; winner's command latched on the edge
// ACCESS  | owner granted; bank written / read at the closing edge
// RESPOND | done pulse to owner; rdata stable
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_a,
  input  logic                 write_a,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [WIDTH-1:0]     wdata_a,
  input  logic                 req_b,
  input  logic                 write_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  input  logic [WIDTH-1:0]     wdata_b,
  output logic                 grant_a,
  output logic                 grant_b,
  output logic                 done_a,
  output logic                 done_b,
  output logic [WIDTH-1:0]     rdata
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_served_q, last_served_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_BITS-1:0]  cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0]      bank_q [DEPTH];
  logic [WIDTH-1:0]      bank_d [DEPTH];

  logic winner;
  logic any_req;

  round_robin_arbiter_2 u_arb (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_served (last_served_q),
    .winner      (winner),
    .any_req     (any_req)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    cmd_write_d   = cmd_write_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    rdata_d       = rdata_q;
    bank_d        = bank_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = winner;
          // Command is frozen here so later input changes cannot disturb it.
          if (winner == OWNER_B) begin
            cmd_write_d = write_b;
            cmd_addr_d  = addr_b;
            cmd_wdata_d = wdata_b;
          end else begin
            cmd_write_d = write_a;
            cmd_addr_d  = addr_a;
            cmd_wdata_d = wdata_a;
          end
        end
      end
      ACCESS: begin
        state_d       = RESPOND;
        last_served_d = owner_q;
        if (cmd_write_q) begin
          bank_d[cmd_addr_q] = cmd_wdata_q;
          rdata_d            = cmd_wdata_q;
        end else begin
          rdata_d = bank_q[cmd_addr_q];
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_A;
      // Reset to B so that A wins the first tie.
      last_served_q <= OWNER_B;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      rdata_q       <= '0;
      bank_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      cmd_write_q   <= cmd_write_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      rdata_q       <= rdata_d;
      bank_q        <= bank_d;
    end
  end

  assign grant_a = (state_q == ACCESS)  && (owner_q == OWNER_A);
  assign grant_b = (state_q == ACCESS)  && (owner_q == OWNER_B);
  assign done_a  = (state_q == RESPOND) && (owner_q == OWNER_A);
  assign done_b  = (state_q == RESPOND) && (owner_q == OWNER_B);
  assign rdata   = rdata_q;

endmodule
